pxs_stream_gen: RTL and testbench

PXS_STREAM_GEN -- requirements
Module: pxs_stream_gen

---
 rtl/pxs_pkg.sv | 37 +++
 rtl/pxs_stream_gen_if.sv | 10 +
 rtl/pxs_timing_counter.sv | 35 +++
 rtl/pxs_stream_gen.sv | 113 +++++++++++
 tb/tb_pxs_stream_gen.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pxs_pkg.sv
// Shared stream layout and default 640x480 timing for the pixel stream generator.
package pxs_pkg;

  localparam int unsigned STR_W   = 26;
  localparam int unsigned COORD_W = 10;

  localparam int unsigned ACT_BIT = 0;
  localparam int unsigned VS_BIT  = 1;
  localparam int unsigned HS_BIT  = 2;
  localparam int unsigned YC_LSB  = 3;
  localparam int unsigned YC_MSB  = 12;
  localparam int unsigned XC_LSB  = 13;
  localparam int unsigned XC_MSB  = 22;
  localparam int unsigned R_BIT   = 23;
  localparam int unsigned G_BIT   = 24;
  localparam int unsigned B_BIT   = 25;

  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  // Packed MSB-first so the struct overlays the 26-bit stream word bit for bit.
  typedef struct packed {
    logic [2:0]         bgr;
    logic [COORD_W-1:0] xc;
    logic [COORD_W-1:0] yc;
    logic               hs;
    logic               vs;
    logic               active;
  } pxs_word_t;

endpackage

// File: rtl/pxs_stream_gen_if.sv
// Pixel stream bundle: 26-bit stream word plus start-of-frame pulse.
interface pxs_stream_gen_if;
  import pxs_pkg::*;

  logic [STR_W-1:0] RGBStr_o;
  logic             frame_o;

  modport master (output RGBStr_o, output frame_o);
  modport slave  (input  RGBStr_o, input  frame_o);
endinterface

// File: rtl/pxs_timing_counter.sv
// Wrapping 0..LIMIT-1 counter with a registered strobe that is high while count sits at LIMIT-1.
module pxs_timing_counter #(
  parameter int unsigned LIMIT = 800,
  parameter int unsigned CNT_W = 10
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (en) begin
      count_nxt = (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // The strobe is computed from the next count so it lines up with count==LAST, not one cycle behind.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= (LAST == '0);
    end else begin
      count <= count_nxt;
      wrap  <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/pxs_stream_gen.sv
// Raster timing generator producing a registered 26-bit pixel stream and frame pulse.
// Optional 8-bar colour test pattern is compiled in with `define PXS_TESTPATTERN_EN.
module pxs_stream_gen
  import pxs_pkg::*;
#(
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_VIS    = DEF_V_VIS,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              px_clk,
  input  logic              rst_n,
  pxs_stream_gen_if.master  str
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_timing_range_check
    $fatal(1, "pxs_stream_gen: line or frame total exceeds the 10-bit coordinate range");
  end

  localparam pxs_word_t RST_WORD = '{
    bgr:    '0,
    xc:     '0,
    yc:     '0,
    hs:     ~SYNC_POL,
    vs:     ~SYNC_POL,
    active: 1'b0
  };

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap;
  logic               v_wrap;
  int unsigned        hc_u;
  int unsigned        vc_u;
  pxs_word_t          word_nxt;
  pxs_word_t          word_q;
  logic               first_q;
  logic               frame_q;

  pxs_timing_counter #(
    .LIMIT (H_TOT),
    .CNT_W (COORD_W)
  ) u_hcnt (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .count  (h_cnt),
    .wrap   (h_wrap)
  );

  pxs_timing_counter #(
    .LIMIT (V_TOT),
    .CNT_W (COORD_W)
  ) u_vcnt (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .en     (h_wrap),
    .count  (v_cnt),
    .wrap   (v_wrap)
  );

  always_comb begin
    hc_u = 32'(h_cnt);
    vc_u = 32'(v_cnt);
  end

`ifdef PXS_TESTPATTERN_EN
  localparam int unsigned BAR_W = (H_VIS >= 8) ? H_VIS / 8 : 1;
  int unsigned bar_idx;
  always_comb begin
    bar_idx = hc_u / BAR_W;
  end
`endif

  always_comb begin
    word_nxt        = '0;
    word_nxt.xc     = h_cnt;
    word_nxt.yc     = v_cnt;
    word_nxt.active = (hc_u < H_VIS) && (vc_u < V_VIS);
    word_nxt.hs     = ((hc_u >= H_VIS + H_FP) && (hc_u < H_VIS + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    word_nxt.vs     = ((vc_u >= V_VIS + V_FP) && (vc_u < V_VIS + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
`ifdef PXS_TESTPATTERN_EN
    if (word_nxt.active && bar_idx < 8) begin
      word_nxt.bgr = 3'(7 - bar_idx);
    end
`endif
  end

  // first_q tracks "counters are at (0,0)" using the wrap strobes instead of a 20-bit compare.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= RST_WORD;
      first_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      word_q  <= word_nxt;
      first_q <= h_wrap & v_wrap;
      frame_q <= first_q;
    end
  end

  assign str.RGBStr_o = word_q;
  assign str.frame_o  = frame_q;

endmodule

// File: tb/tb_pxs_stream_gen.sv
// Directed and per-cycle reference checks of pxs_stream_gen at default and reduced timing.
module tb_pxs_stream_gen;

  logic        px_clk = 1'b0;
  logic        rst_n  = 1'b0;
  int unsigned n_vec  = 0;
  int unsigned n_bad  = 0;
  int unsigned cyc    = 0;

  always #5 px_clk = ~px_clk;

  pxs_stream_gen_if d_if ();
  pxs_stream_gen_if s_if ();

  pxs_stream_gen u_dut_def (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .str    (d_if)
  );

  pxs_stream_gen #(
    .H_VIS    (64),
    .H_FP     (8),
    .H_SYNC   (8),
    .H_BP     (8),
    .V_VIS    (20),
    .V_FP     (2),
    .V_SYNC   (3),
    .V_BP     (5),
    .SYNC_POL (1'b1)
  ) u_dut_sm (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .str    (s_if)
  );

`ifdef PXS_TESTPATTERN_EN
  localparam logic [2:0] TP_X0  = 3'd7;
  localparam logic [2:0] TP_X80 = 3'd6;
`else
  localparam logic [2:0] TP_X0  = 3'd0;
  localparam logic [2:0] TP_X80 = 3'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] mk_word(input int unsigned x, input int unsigned y,
                                          input int unsigned hvis, input int unsigned hfp,
                                          input int unsigned hsync, input int unsigned vvis,
                                          input int unsigned vfp, input int unsigned vsync,
                                          input bit pol);
    logic       act;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
    act = (x < hvis) && (y < vvis);
    hs  = (x >= hvis + hfp && x < hvis + hfp + hsync) ? pol : ~pol;
    vs  = (y >= vvis + vfp && y < vvis + vfp + vsync) ? pol : ~pol;
    rgb = 3'd0;
`ifdef PXS_TESTPATTERN_EN
    if (act) rgb = 3'(7 - x / (hvis / 8));
`endif
    return {rgb, 10'(x), 10'(y), hs, vs, act};
  endfunction

  always @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model: output after k edges describes raster position k-1 counted from reset release.
  always @(negedge px_clk) begin
    if (!rst_n || cyc == 0) begin
      chk("mdl_def_rst", d_if.RGBStr_o, 26'h000_0006);
      chk("mdl_def_rst_frame", d_if.frame_o, 0);
      chk("mdl_sm_rst", s_if.RGBStr_o, 26'h000_0000);
      chk("mdl_sm_rst_frame", s_if.frame_o, 0);
    end else begin
      chk("mdl_def_word", d_if.RGBStr_o,
          mk_word((cyc - 1) % 800, ((cyc - 1) / 800) % 525, 640, 16, 96, 480, 10, 2, 1'b0));
      chk("mdl_def_frame", d_if.frame_o, ((cyc - 1) % 420000) == 0);
      chk("mdl_sm_word", s_if.RGBStr_o,
          mk_word((cyc - 1) % 88, ((cyc - 1) / 88) % 30, 64, 8, 8, 20, 2, 3, 1'b1));
      chk("mdl_sm_frame", s_if.frame_o, ((cyc - 1) % 2640) == 0);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned hs_lo, hs_first, hs_last, act_n, frames, vs_n, vs_min, vs_max;
    logic        found;

    repeat (3) @(negedge px_clk);
    chk("rst_def_word", d_if.RGBStr_o, 26'h000_0006);
    chk("rst_def_frame", d_if.frame_o, 0);
    chk("rst_sm_word", s_if.RGBStr_o, 26'h000_0000);

    #2 rst_n = 1'b1;
    @(negedge px_clk);
    chk("first_xc", d_if.RGBStr_o[22:13], 0);
    chk("first_yc", d_if.RGBStr_o[12:3], 0);
    chk("first_act", d_if.RGBStr_o[0], 1);
    chk("first_hs_vs", d_if.RGBStr_o[2:1], 2'b11);
    chk("first_frame", d_if.frame_o, 1);

    hs_lo = 0; hs_first = 1023; hs_last = 0; act_n = 0;
    for (int unsigned i = 0; i < 800; i++) begin
      if (i != 0) @(negedge px_clk);
      if (!d_if.RGBStr_o[2]) begin
        hs_lo++;
        if (hs_first == 1023) hs_first = 32'(d_if.RGBStr_o[22:13]);
        hs_last = 32'(d_if.RGBStr_o[22:13]);
      end
      if (d_if.RGBStr_o[0]) act_n++;
    end
    chk("line0_hs_low_cnt", hs_lo, 96);
    chk("line0_hs_first", hs_first, 656);
    chk("line0_hs_last", hs_last, 751);
    chk("line0_active_cnt", act_n, 640);
    @(negedge px_clk);
    chk("line1_xc", d_if.RGBStr_o[22:13], 0);
    chk("line1_yc", d_if.RGBStr_o[12:3], 1);

    found = 1'b0;
    for (int unsigned i = 0; i < 9000 && !found; i++) begin
      @(negedge px_clk);
      found = (d_if.RGBStr_o[22:13] == 10'd0) && (d_if.RGBStr_o[12:3] == 10'd10);
    end
    chk("y10_reached", found, 1);
    chk("tp_x0", d_if.RGBStr_o[25:23], TP_X0);
    repeat (80) @(negedge px_clk);
    chk("tp_x80_pos", d_if.RGBStr_o[22:13], 80);
    chk("tp_x80", d_if.RGBStr_o[25:23], TP_X80);
    repeat (559) @(negedge px_clk);
    chk("tp_x639", d_if.RGBStr_o[25:23], 0);
    @(negedge px_clk);
    chk("tp_x640_pos", d_if.RGBStr_o[22:13], 640);
    chk("tp_x640", d_if.RGBStr_o[25:23], 0);

    found = 1'b0;
    for (int unsigned i = 0; i < 3000 && !found; i++) begin
      @(negedge px_clk);
      found = (s_if.RGBStr_o[22:13] == 10'd30) && (s_if.RGBStr_o[12:3] == 10'd12);
    end
    chk("sm_mid_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("sm_async_rst", s_if.RGBStr_o, 26'h000_0000);
    chk("def_async_rst", d_if.RGBStr_o, 26'h000_0006);
    repeat (3) @(negedge px_clk);
    chk("sm_rst_hold", s_if.RGBStr_o, 26'h000_0000);
    #2 rst_n = 1'b1;
    @(negedge px_clk);
    chk("sm_restart_xc", s_if.RGBStr_o[22:13], 0);
    chk("sm_restart_yc", s_if.RGBStr_o[12:3], 0);
    chk("sm_restart_frame", s_if.frame_o, 1);

    frames = 0; vs_n = 0; vs_min = 1023; vs_max = 0;
    for (int unsigned i = 0; i < 2640; i++) begin
      if (i != 0) @(negedge px_clk);
      if (s_if.frame_o) frames++;
      if (s_if.RGBStr_o[1]) begin
        vs_n++;
        if (32'(s_if.RGBStr_o[12:3]) < vs_min) vs_min = 32'(s_if.RGBStr_o[12:3]);
        if (32'(s_if.RGBStr_o[12:3]) > vs_max) vs_max = 32'(s_if.RGBStr_o[12:3]);
      end
    end
    chk("sm_frame_pulses", frames, 1);
    chk("sm_vs_cycles", vs_n, 264);
    chk("sm_vs_first_line", vs_min, 22);
    chk("sm_vs_last_line", vs_max, 24);
    chk("sm_last_xc", s_if.RGBStr_o[22:13], 87);
    chk("sm_last_yc", s_if.RGBStr_o[12:3], 29);
    @(negedge px_clk);
    chk("sm_wrap_xc", s_if.RGBStr_o[22:13], 0);
    chk("sm_wrap_yc", s_if.RGBStr_o[12:3], 0);
    chk("sm_wrap_frame", s_if.frame_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
